// File: rtl/onchip_mem_reader_pkg.sv
// Shared types and constants for the on-chip RAM read master and its output buffer.
package onchip_mem_reader_pkg;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_FIFO_DEPTH   = 8;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/onchip_mem_reader_fifo.sv
// Output buffer for the read master: synchronous FIFO holding {last tag, data} with occupancy output.
module reader_fifo
    import onchip_mem_reader_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_ONE  = 1;
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never reset; flushing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_underflow: assert (!(pop && level_q == '0));
            a_no_overflow:  assert (!(push && level_q == LVL_FULL));
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule

// File: rtl/onchip_mem_reader.sv
// Avalon-MM read master: fetches a block of consecutive RAM words and streams them out in order,
// issuing reads only when the output FIFO is guaranteed room for the returning data.
module onchip_mem_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              read,
    output logic [3:0]        byteenable,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         rem_q, rem_d;
    logic                    done_q, done_d;
    logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [READ_LATENCY-1:0] rd_last_q, rd_last_d;

    logic             issue;
    logic             pop;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [DATA_W:0]  fifo_head;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occupancy;

    always_comb begin
        // Credit check: buffered words plus reads still in flight must leave a free slot.
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(rd_vld_q[i]);
        end
        occupancy = CNT_W'(fifo_level) + inflight;
        issue     = (state_q == ST_FETCH) && (occupancy < CNT_W'(FIFO_DEPTH));
        pop       = !fifo_empty && out_ready;

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d = ST_FETCH;
                        addr_d  = base_addr;
                        rem_d   = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[DATA_W]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_vld_d[0]  = issue;
        rd_last_d[0] = issue && (rem_q == (ADDR_W+1)'(1));
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i]  = rd_vld_q[i-1];
            rd_last_d[i] = rd_last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            rd_vld_q  <= '0;
            rd_last_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    // Response tap: the oldest in-flight slot lands in the FIFO together with its last tag.
    reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_vld_q[READ_LATENCY-1]),
        .push_data ({rd_last_q[READ_LATENCY-1], readdata}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign address    = addr_q;
    assign chipselect = issue;
    assign read       = issue;
    assign byteenable = issue ? BYTEEN_ALL : 4'h0;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign out_last   = !fifo_empty && fifo_head[DATA_W];

endmodule
